line_buf_ver: RTL
=================

LINE_BUF_VER -- requirements
Module: line_buf_ver

Interface
REQ-001 The block SHALL have parameter DBUF_DW, default 8, meaning pixel data width.
REQ-002 The block SHALL have parameter KRNV_SZ, default 6, meaning vertical kernel size (lines per output column), minimum 2.
REQ-003 The block SHALL have parameter IMG_HSZ, default 1920, meaning maximum active pixels per line.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock for the block.
REQ-005 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port i_data, input, DBUF_DW bits, raster pixel.
REQ-007 The block SHALL have ports i_href, i_hstr, i_hend, i_vstr and i_vend, each an input of 1 bit, with these meanings: i_href = pixel valid; i_hstr = first pixel of a line (coincident with i_href); i_hend = last pixel of a line (coincident with i_href); i_vstr = frame start pulse (at or before the first i_hstr); i_vend = frame end pulse (at or after the last i_hend).
REQ-008 The block SHALL have port o_data, output, DBUF_DW*KRNV_SZ bits, vertical column; slice [DBUF_DW-1:0] is the current-line pixel and the top slice is the oldest line.
REQ-009 The block SHALL have ports o_dvld, o_hstr, o_hend, o_vstr and o_vend, each an output of 1 bit, carrying column valid, line start, line end, frame start and frame end, directly consumable by the downstream line_rng column stage.

Function
REQ-010 The block SHALL store KRNV_SZ-1 line memories, each IMG_HSZ x DBUF_DW, used as a circular set selected by line pointer lptr (0..KRNV_SZ-2).
REQ-011 The block SHALL keep column counter col_cnt, which is cleared on i_hstr (that pixel uses column 0), incremented per i_href pixel, and saturates at IMG_HSZ-1.
REQ-012 On an i_href pixel the block SHALL do two things in the same cycle: read every memory at col_cnt, and write i_data into memory lptr at col_cnt; the read returns the old data (read-before-write).
REQ-013 Pixels beyond IMG_HSZ SHALL be dropped: no memory write, no o_dvld.
REQ-014 lptr SHALL advance on i_href & i_hend, and SHALL wrap from KRNV_SZ-2 to 0.
REQ-015 The column order SHALL be oldest-to-newest, resolved from lptr: the memory lptr holds line N-(KRNV_SZ-1), and memory lptr+k (mod KRNV_SZ-1) holds line N-(KRNV_SZ-1)+k.
REQ-016 The block SHALL implement an FSM with states IDLE, FILL and RUN (one-hot); lptr and line count lcnt reset to 0.
REQ-017 In IDLE, i_vstr SHALL clear lptr, lcnt and col_cnt, and move the FSM to FILL.
REQ-018 In FILL, each i_hend SHALL increment lcnt; when lcnt reaches KRNV_SZ-1 the FSM SHALL move to RUN on the cycle after that i_hend.
REQ-019 In RUN, i_vend SHALL move the FSM to IDLE.
REQ-020 i_vstr in FILL or RUN SHALL restart the frame: clear lptr, lcnt and col_cnt, and go to FILL.
REQ-021 In FILL the block SHALL write memories but assert no o_dvld, o_hstr or o_hend.
REQ-022 In RUN, o_dvld, o_hstr, o_hend and o_data SHALL be registered copies of i_href, i_hstr, i_hend and the assembled column, with a latency of exactly 1 cycle.
REQ-023 o_data SHALL be 0 whenever o_dvld is 0.
REQ-024 o_vstr SHALL pulse together with the first o_hstr of the frame.
REQ-025 o_vend SHALL be i_vend delayed 1 cycle, asserted only if the FSM was in RUN.
REQ-026 i_vend in FILL SHALL return the FSM to IDLE with no o_vend.
REQ-027 The block SHALL ignore inputs (no writes) while in IDLE.
REQ-028 If i_hstr and i_hend occur together (1-pixel line), the block SHALL treat the pixel as both line start and line end.

Reset
REQ-029 While rst_n is 0, the block SHALL force all outputs to 0, the FSM to IDLE, and lptr, lcnt, col_cnt and all pipeline registers to 0; the memory contents are don't-care.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately; after release the block SHALL wait for i_vstr and produce no output before it.

Verification (KRNV_SZ=3, IMG_HSZ=8, DBUF_DW=8, pixel = 16*line + col)
REQ-031 Bench scenario: a 4-line x 4-pixel frame -> lines 0-1 produce no o_dvld; at line 2 col 1, o_data = 0x011121; at line 3 col 3, o_data = 0x132333.
REQ-032 Bench scenario: timing check on the same frame -> o_hstr one cycle after the line-2 i_hstr; o_vstr coincident with it; o_vend one cycle after i_vend.
REQ-033 Bench scenario: a 10-pixel line with IMG_HSZ=8 -> exactly 8 o_dvld cycles; the next line reads the correct col 0-7 data.
REQ-034 Bench scenario: an 8-line frame (lptr wraps repeatedly) -> every column equals {line n-2, n-1, n} pixels at the same col.
REQ-035 Bench scenario: i_vstr re-issued after 1 line, and separately rst_n pulsed mid-line -> no output until 2 new lines have been buffered; all outputs 0 during reset.
REQ-036 Bench scenario: i_vend after only 1 line -> FSM returns to IDLE; o_vend stays 0.

Source files
------------

// File: rtl/line_buf_ver.sv
// line_buf_ver: vertical line buffer. It assembles KRNV_SZ-tall pixel columns from a
// raster stream, using KRNV_SZ-1 line memories that rotate as a circular set.
module line_buf_ver #(
  parameter int DBUF_DW = 8,
  parameter int KRNV_SZ = 6,
  parameter int IMG_HSZ = 1920
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DBUF_DW-1:0]         i_data,
  input  logic                       i_href,
  input  logic                       i_hstr,
  input  logic                       i_hend,
  input  logic                       i_vstr,
  input  logic                       i_vend,
  output logic [DBUF_DW*KRNV_SZ-1:0] o_data,
  output logic                       o_dvld,
  output logic                       o_hstr,
  output logic                       o_hend,
  output logic                       o_vstr,
  output logic                       o_vend
);

  localparam int NL  = KRNV_SZ - 1;
  localparam int LPW = (NL > 1) ? $clog2(NL) : 1;
  localparam int LCW = $clog2(KRNV_SZ);
  localparam int CW  = (IMG_HSZ > 1) ? $clog2(IMG_HSZ) : 1;

  localparam logic [CW-1:0]  COL_MAX   = CW'(IMG_HSZ - 1);
  localparam logic [LPW-1:0] LPTR_MAX  = LPW'(NL - 1);
  localparam logic [LCW-1:0] LCNT_FULL = LCW'(NL);
  localparam logic [LCW-1:0] LCNT_LAST = LCW'(NL - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_FILL = 3'b010,
    ST_RUN  = 3'b100
  } state_t;

  state_t state_r;
  state_t state_s;

  logic [LPW-1:0] lptr_r;
  logic [LCW-1:0] lcnt_r;
  logic [CW-1:0]  col_cnt_r;
  logic           ovf_r;
  logic           first_r;

  logic [CW-1:0]  col_s;
  logic [CW-1:0]  col_nxt_s;
  logic           ovf_nxt_s;
  logic           drop_s;
  logic           act_s;
  logic           run_s;
  logic           wr_en_s;
  logic           line_end_s;

  logic [DBUF_DW-1:0]         mem_r [NL][IMG_HSZ];
  logic [DBUF_DW-1:0]         rd_s  [NL];
  logic [DBUF_DW*KRNV_SZ-1:0] column_s;

  logic                       dvld_s;
  logic                       hstr_s;
  logic                       hend_s;
  logic                       vstr_s;
  logic                       vend_s;
  logic [DBUF_DW*KRNV_SZ-1:0] data_s;

  // Memory holding the k-th oldest buffered line, counted from the oldest at lptr
  function automatic logic [LPW-1:0] rot_idx(input logic [LPW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    rot_idx = (s >= NL) ? LPW'(s - NL) : LPW'(s);
  endfunction

  // Pixel qualification: the line-start pixel always lands in column 0
  always_comb begin
    col_s      = i_hstr ? '0 : col_cnt_r;
    drop_s     = i_hstr ? 1'b0 : ovf_r;
    act_s      = (state_r == ST_FILL) || (state_r == ST_RUN);
    run_s      = (state_r == ST_RUN);
    wr_en_s    = act_s & i_href & ~drop_s & ~i_vstr;
    line_end_s = act_s & i_href & i_hend & ~i_vstr;
    if (col_s == COL_MAX) begin
      col_nxt_s = col_s;
      ovf_nxt_s = 1'b1;
    end else begin
      col_nxt_s = col_s + 1'b1;
      ovf_nxt_s = drop_s;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a frame start always wins over every other event
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_vstr) begin
          state_s = ST_FILL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (i_vstr) begin
          state_s = ST_FILL;
        end else if (i_vend) begin
          state_s = ST_IDLE;
        end else if (line_end_s && (lcnt_r == LCNT_LAST)) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_RUN: begin
        if (i_vstr) begin
          state_s = ST_FILL;
        end else if (i_vend) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Frame bookkeeping: line pointer, fill count, column position, first-line flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lptr_r    <= '0;
      lcnt_r    <= '0;
      col_cnt_r <= '0;
      ovf_r     <= 1'b0;
      first_r   <= 1'b0;
    end else if (i_vstr) begin
      lptr_r    <= '0;
      lcnt_r    <= '0;
      col_cnt_r <= '0;
      ovf_r     <= 1'b0;
      first_r   <= 1'b1;
    end else begin
      if (act_s && i_href) begin
        col_cnt_r <= col_nxt_s;
        ovf_r     <= ovf_nxt_s;
      end
      if (line_end_s) begin
        lptr_r <= (lptr_r == LPTR_MAX) ? '0 : lptr_r + 1'b1;
      end
      if (line_end_s && (state_r == ST_FILL) && (lcnt_r != LCNT_FULL)) begin
        lcnt_r <= lcnt_r + 1'b1;
      end
      if (hstr_s) begin
        first_r <= 1'b0;
      end
    end
  end

  // Line memories: the contents need no reset because reads before a fill are never output
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[lptr_r][col_s] <= i_data;
    end
  end

  // Read-before-write: the combinational read returns the data that was stored before this edge
  for (genvar m = 0; m < NL; m++) begin : g_rd
    assign rd_s[m] = mem_r[m][col_s];
  end

  // The current pixel sits in the bottom slice and the oldest line in the top slice
  assign column_s[DBUF_DW-1:0] = i_data;
  for (genvar k = 0; k < NL; k++) begin : g_col
    assign column_s[(KRNV_SZ-1-k)*DBUF_DW +: DBUF_DW] = rd_s[rot_idx(lptr_r, k)];
  end

  // Output decode; outputs are produced only while the buffer is full
  always_comb begin
    dvld_s = run_s & i_href & ~i_vstr & ~drop_s;
    hstr_s = run_s & i_href & ~i_vstr & i_hstr;
    hend_s = run_s & i_href & ~i_vstr & i_hend;
    vstr_s = hstr_s & first_r;
    vend_s = run_s & i_vend;
    if (dvld_s) begin
      data_s = column_s;
    end else begin
      data_s = '0;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data <= '0;
      o_dvld <= 1'b0;
      o_hstr <= 1'b0;
      o_hend <= 1'b0;
      o_vstr <= 1'b0;
      o_vend <= 1'b0;
    end else begin
      o_data <= data_s;
      o_dvld <= dvld_s;
      o_hstr <= hstr_s;
      o_hend <= hend_s;
      o_vstr <= vstr_s;
      o_vend <= vend_s;
    end
  end

endmodule
